// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with load/pause/run control and a one-second prescaler.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the preset on expiry instead of stopping.
module countdown_timer #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       load,
  input  logic [3:0] load_sec_ones,
  input  logic [3:0] load_sec_tens,
  input  logic [3:0] load_min_ones,
  input  logic [3:0] load_min_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       expired,
  output logic       done
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, PAUSE, RUN, EXPIRED} state_t;
  state_t state, state_next;

  logic [PW-1:0] presc;
  logic [3:0] c_so, c_st, c_mo, c_mt;
  logic [3:0] d_so, d_st, d_mo, d_mt;
  logic       load_zero, tick, hits_zero;

  always_comb begin
    c_so = (load_sec_ones > 4'd9) ? 4'd9 : load_sec_ones;
    c_st = (load_sec_tens > 4'd5) ? 4'd5 : load_sec_tens;
    c_mo = (load_min_ones > 4'd9) ? 4'd9 : load_min_ones;
    c_mt = (load_min_tens > 4'd9) ? 4'd9 : load_min_tens;
    load_zero = ({c_mt, c_mo, c_st, c_so} == 16'h0000);
  end

  assign tick      = (state == RUN) && (presc == PMAX);
  assign hits_zero = tick && ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0001);
  assign running   = (state == RUN);
  assign expired   = (state == EXPIRED);

  // BCD decrement with borrow chain; never applied to 00:00 since RUN is left or reloaded first
  always_comb begin
    d_so = sec_ones;
    d_st = sec_tens;
    d_mo = min_ones;
    d_mt = min_tens;
    if (sec_ones != 4'd0) begin
      d_so = sec_ones - 4'd1;
    end else begin
      d_so = 4'd9;
      if (sec_tens != 4'd0) begin
        d_st = sec_tens - 4'd1;
      end else begin
        d_st = 4'd5;
        if (min_ones != 4'd0) begin
          d_mo = min_ones - 4'd1;
        end else begin
          d_mo = 4'd9;
          d_mt = min_tens - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (load) begin
      state_next = load_zero ? IDLE : PAUSE;
    end else begin
      case (state)
        PAUSE: if (start_stop) state_next = RUN;
        RUN: begin
          if (!start_stop) state_next = PAUSE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
`else
          if (hits_zero) state_next = EXPIRED;
`endif
        end
        default: state_next = state;
      endcase
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [3:0] pre_so, pre_st, pre_mo, pre_mt;

  always_ff @(posedge clk) begin
    if (reset) begin
      {pre_mt, pre_mo, pre_st, pre_so} <= '0;
    end else if (load) begin
      {pre_mt, pre_mo, pre_st, pre_so} <= {c_mt, c_mo, c_st, c_so};
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      {min_tens, min_ones, sec_tens, sec_ones} <= '0;
      presc <= '0;
      done  <= 1'b0;
    end else if (load) begin
      {min_tens, min_ones, sec_tens, sec_ones} <= {c_mt, c_mo, c_st, c_so};
      presc <= '0;
      done  <= 1'b0;
    end else begin
      done <= hits_zero;
      if (state == RUN) begin
        presc <= (presc == PMAX) ? '0 : presc + 1'b1;
      end
      if (tick) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        if (hits_zero) begin
          {min_tens, min_ones, sec_tens, sec_ones} <= {pre_mt, pre_mo, pre_st, pre_so};
        end else begin
          {min_tens, min_ones, sec_tens, sec_ones} <= {d_mt, d_mo, d_st, d_so};
        end
`else
        {min_tens, min_ones, sec_tens, sec_ones} <= {d_mt, d_mo, d_st, d_so};
`endif
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer at TICKS_PER_SEC=4.
module tb_countdown_timer;

  logic clk = 1'b0;
  logic reset, start_stop, load;
  logic [3:0] load_sec_ones, load_sec_tens, load_min_ones, load_min_tens;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic running, expired, done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt;

  countdown_timer #(.TICKS_PER_SEC(4)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .load(load),
    .load_sec_ones(load_sec_ones), .load_sec_tens(load_sec_tens),
    .load_min_ones(load_min_ones), .load_min_tens(load_min_tens),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .running(running), .expired(expired), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] preset;
    int          run;
    logic [15:0] exp_count;
    logic        exp_running;
    logic        exp_expired;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [15:0] count_now();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load = 1'b0;
    start_stop = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones} = v;
    step();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_stop = 1'b0; load = 1'b0;
    {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones} = 16'h0000;

    // Reset held three cycles
    repeat (3) step();
    check("reset_count", count_now(), 16'h0000);
    check("reset_running", {15'b0, running}, 16'd0);
    check("reset_expired", {15'b0, expired}, 16'd0);
    check("reset_done", {15'b0, done}, 16'd0);
    reset = 1'b0;

    vecs[0] = '{16'h0003, 4, 16'h0002, 1'b1, 1'b0};
    vecs[1] = '{16'h1000, 4, 16'h0959, 1'b1, 1'b0};
    vecs[2] = '{16'h0010, 4, 16'h0009, 1'b1, 1'b0};
    vecs[3] = '{16'hFC7A, 0, 16'h9959, 1'b1, 1'b0};
    vecs[4] = '{16'h1260, 4, 16'h1249, 1'b1, 1'b0};
    vecs[5] = '{16'h0100, 8, 16'h0058, 1'b1, 1'b0};
    vecs[6] = '{16'h0000, 4, 16'h0000, 1'b0, 1'b0};
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    vecs[7] = '{16'h0001, 4, 16'h0001, 1'b1, 1'b0};
`else
    vecs[7] = '{16'h0001, 4, 16'h0000, 1'b0, 1'b1};
`endif

    for (int i = 0; i < 8; i++) begin
      do_reset();
      do_load(vecs[i].preset);
      start_stop = 1'b1;
      step();
      repeat (vecs[i].run) step();
      check($sformatf("vec%0d_count", i), count_now(), vecs[i].exp_count);
      check($sformatf("vec%0d_running", i), {15'b0, running}, {15'b0, vecs[i].exp_running});
      check($sformatf("vec%0d_expired", i), {15'b0, expired}, {15'b0, vecs[i].exp_expired});
      start_stop = 1'b0;
    end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Auto-reload: 00:02 runs 00:01 then reloads to 00:02 with one done pulse
    do_reset();
    do_load(16'h0002);
    start_stop = 1'b1;
    step();
    done_cnt = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (done) done_cnt++;
      if (k == 4) check("ar_c4", count_now(), 16'h0001);
      if (k == 8) begin
        check("ar_c8", count_now(), 16'h0002);
        check("ar_done8", {15'b0, done}, 16'd1);
        check("ar_running8", {15'b0, running}, 16'd1);
      end
    end
    check("ar_done_count", 16'(done_cnt), 16'd1);
    check("ar_expired", {15'b0, expired}, 16'd0);
`else
    // Full run of 00:03 to expiry
    do_reset();
    do_load(16'h0003);
    start_stop = 1'b1;
    step();
    check("run3_running", {15'b0, running}, 16'd1);
    done_cnt = 0;
    for (int k = 1; k <= 13; k++) begin
      step();
      if (done) done_cnt++;
      if (k == 3)  check("run3_c3", count_now(), 16'h0003);
      if (k == 4)  check("run3_c4", count_now(), 16'h0002);
      if (k == 8)  check("run3_c8", count_now(), 16'h0001);
      if (k == 12) begin
        check("run3_c12", count_now(), 16'h0000);
        check("run3_done12", {15'b0, done}, 16'd1);
        check("run3_expired12", {15'b0, expired}, 16'd1);
        check("run3_running12", {15'b0, running}, 16'd0);
      end
    end
    check("run3_done_count", 16'(done_cnt), 16'd1);
    start_stop = 1'b0;
    step();
    start_stop = 1'b1;
    repeat (5) step();
    check("exp_hold_count", count_now(), 16'h0000);
    check("exp_hold_expired", {15'b0, expired}, 16'd1);
    do_load(16'h0002);
    check("exp_load_count", count_now(), 16'h0002);
    check("exp_load_expired", {15'b0, expired}, 16'd0);
    check("exp_load_running", {15'b0, running}, 16'd0);
    start_stop = 1'b0;
`endif

    // Pause keeps the partial second
    do_reset();
    do_load(16'h0005);
    start_stop = 1'b1;
    step();
    step();
    start_stop = 1'b0;
    step();
    repeat (10) step();
    check("pause_count", count_now(), 16'h0005);
    check("pause_running", {15'b0, running}, 16'd0);
    start_stop = 1'b1;
    step();
    step();
    check("resume_c1", count_now(), 16'h0005);
    step();
    check("resume_c2", count_now(), 16'h0004);

    // Load on a tick cycle wins, and clears the prescaler
    do_reset();
    do_load(16'h0030);
    start_stop = 1'b1;
    step();
    repeat (3) step();
    do_load(16'h0020);
    check("ldtick_count", count_now(), 16'h0020);
    check("ldtick_running", {15'b0, running}, 16'd0);
    step();
    repeat (3) step();
    check("ldtick_c3", count_now(), 16'h0020);
    step();
    check("ldtick_c4", count_now(), 16'h0019);

    // Reset mid-count overrides load and aborts counting
    do_reset();
    do_load(16'h0005);
    start_stop = 1'b1;
    repeat (6) step();
    check("mid_count", count_now(), 16'h0004);
    reset = 1'b1;
    load = 1'b1;
    {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones} = 16'h0009;
    step();
    check("rst_over_load_count", count_now(), 16'h0000);
    check("rst_over_load_running", {15'b0, running}, 16'd0);
    reset = 1'b0;
    load = 1'b0;
    repeat (5) step();
    check("idle_ignores_start", {15'b0, running}, 16'd0);
    check("idle_count", count_now(), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
